// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer: sequences a WIDTH-bit shift register for PISO
// transfers or SIPO captures, one bit per clock, MSB first. Commands arrive
// over a valid/ready handshake; completion is signalled by a one-cycle done.
// Optional feature macro: SHREG_PARITY_EN adds a trailing even-parity bit
// (PAR state) to both directions and drives parity_err on SIPO completion.
module shift_reg_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  output logic             sout,
  output logic             sout_valid,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  output logic             done,
  output logic             busy,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef SHREG_PARITY_EN
    PAR   = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             mode_reg, mode_next;
  logic [WIDTH-1:0] pout_reg, pout_next;
`ifdef SHREG_PARITY_EN
  logic             txpar_reg, txpar_next;
  logic             perr_reg, perr_next;
`endif

  // Next-state and datapath updates; every register holds unless its state acts on it.
  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;
    pout_next  = pout_reg;
`ifdef SHREG_PARITY_EN
    txpar_next = txpar_reg;
    perr_next  = perr_reg;
`endif
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (start_valid) begin
          mode_next  = mode;
          shreg_next = mode ? '0 : din;
`ifdef SHREG_PARITY_EN
          txpar_next = ^din;
`endif
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // PISO shifts zeros in behind the data; SIPO shifts the link bit in.
        shreg_next = {shreg_reg[WIDTH-2:0], (mode_reg ? sin : 1'b0)};
        cnt_next   = cnt_reg + 1'b1;
        if (cnt_reg == LAST) begin
`ifdef SHREG_PARITY_EN
          state_next = PAR;
`else
          state_next = DONE;
          // Capture lands in pout on the same edge that enters DONE.
          if (mode_reg) pout_next = {shreg_reg[WIDTH-2:0], sin};
`endif
        end
      end
`ifdef SHREG_PARITY_EN
      PAR: begin
        // sin now carries the received parity bit; shreg already holds the word.
        perr_next = (^shreg_reg) ^ sin;
        if (mode_reg) pout_next = shreg_reg;
        state_next = DONE;
      end
`endif
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset (reset aborts any command).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      cnt_reg   <= '0;
      mode_reg  <= 1'b0;
      pout_reg  <= '0;
`ifdef SHREG_PARITY_EN
      txpar_reg <= 1'b0;
      perr_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
      pout_reg  <= pout_next;
`ifdef SHREG_PARITY_EN
      txpar_reg <= txpar_next;
      perr_reg  <= perr_next;
`endif
    end
  end

  // All outputs decode registered state only.
  assign start_ready = (state_reg == IDLE);
  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == DONE);
  assign pout_valid  = (state_reg == DONE) && mode_reg;
  assign pout        = pout_reg;

`ifdef SHREG_PARITY_EN
  assign sout_valid = ((state_reg == SHIFT) || (state_reg == PAR)) && !mode_reg;
  assign sout       = sout_valid && ((state_reg == PAR) ? txpar_reg : shreg_reg[WIDTH-1]);
  assign parity_err = (state_reg == DONE) && mode_reg && perr_reg;
`else
  assign sout_valid = (state_reg == SHIFT) && !mode_reg;
  assign sout       = sout_valid && shreg_reg[WIDTH-1];
  assign parity_err = 1'b0;
`endif

endmodule
